fpa_accum: RTL and testbench

Sequencer that sits directly in front of the 8-bit floating-point adder (FPA) and consumes its result. It accepts a stream of 8-bit floats (sign[7], exp[6:3], mant[2:0], implicit leading 1), runs them pairwise through the FPA, and keeps the running sum in an accumulator. When a packet ends (`in_last`), it presents the total on a valid/ready output. It also handles what the FPA cannot: exact cancellation to zero, and optionally a hung adder.

---
 rtl/fpa_accum_if.sv | 33 +++
 rtl/fpa_accum.sv | 155 +++++++++++++++
 tb/tb_fpa_accum.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpa_accum_if.sv
// rtl/fpa_accum_if.sv - operand stream, result stream and FPA handshake bundle for fpa_accum
interface fpa_accum_if #(
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_data;
  logic               out_zero;
  logic [COUNT_W-1:0] out_count;
  logic               out_err;
  logic               fpa_clr;
  logic               fpa_go;
  logic [7:0]         fpa_a;
  logic [7:0]         fpa_b;
  logic               fpa_done;
  logic [7:0]         fpa_sum;

  modport master (
    output in_valid, in_data, in_last, out_ready, fpa_done, fpa_sum,
    input  in_ready, out_valid, out_data, out_zero, out_count, out_err,
           fpa_clr, fpa_go, fpa_a, fpa_b
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready, fpa_done, fpa_sum,
    output in_ready, out_valid, out_data, out_zero, out_count, out_err,
           fpa_clr, fpa_go, fpa_a, fpa_b
  );
endinterface

// File: rtl/fpa_accum.sv
// rtl/fpa_accum.sv - packet accumulator sequencing an 8-bit FP adder
// FPA_ACCUM_TIMEOUT_EN enables the WAIT timeout (TIMEOUT cycles) and out_err.
module fpa_accum #(
  parameter int COUNT_W = 8,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        clr,
  fpa_accum_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_CLR,
    S_GO,
    S_WAIT,
    S_OUT
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [7:0]         acc;
  logic [7:0]         opb;
  logic               acc_zero;
  logic               last_q;
  logic               err;
  logic [COUNT_W-1:0] cnt;
  logic               take;
  logic               cancel;
  logic               timeout;
  logic               resolve;

  assign take    = (state == S_ACCEPT) && bus.in_valid;
  // Equal magnitude with opposite sign: the adder cannot normalise an exact zero.
  assign cancel  = !acc_zero && (acc[6:0] == bus.in_data[6:0]) && (acc[7] != bus.in_data[7]);
  assign resolve = (state == S_WAIT) && (bus.fpa_done || timeout);

`ifdef FPA_ACCUM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;

  assign timeout = (state == S_WAIT) && !bus.fpa_done && (wcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wcnt <= '0;
    end else if (state != S_WAIT) begin
      wcnt <= '0;
    end else if (!bus.fpa_done) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_ACCEPT;
      S_ACCEPT: begin
        if (take) begin
          if (acc_zero || cancel) begin
            state_nx = bus.in_last ? S_OUT : S_ACCEPT;
          end else begin
            state_nx = S_CLR;
          end
        end
      end
      S_CLR:    state_nx = S_GO;
      S_GO:     state_nx = S_WAIT;
      S_WAIT:   if (resolve) state_nx = last_q ? S_OUT : S_ACCEPT;
      S_OUT:    if (bus.out_ready) state_nx = S_ACCEPT;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.out_zero  = 1'b0;
    bus.out_count = '0;
    bus.out_err   = 1'b0;
    bus.fpa_go    = 1'b0;
    bus.fpa_clr   = 1'b1;
    case (state)
      S_ACCEPT: bus.in_ready = 1'b1;
      S_GO: begin
        bus.fpa_go  = 1'b1;
        bus.fpa_clr = 1'b0;
      end
      S_WAIT:   bus.fpa_clr = 1'b0;
      S_OUT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = acc_zero ? 8'h00 : acc;
        bus.out_zero  = acc_zero;
        bus.out_count = cnt;
        bus.out_err   = err;
      end
      default: ;
    endcase
  end

  assign bus.fpa_a = acc;
  assign bus.fpa_b = opb;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc      <= 8'h00;
      opb      <= 8'h00;
      acc_zero <= 1'b1;
      last_q   <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
    end else begin
      if (take) begin
        opb    <= bus.in_data;
        last_q <= bus.in_last;
        if (cnt != '1) cnt <= cnt + 1'b1;
        if (acc_zero) begin
          acc      <= bus.in_data;
          acc_zero <= 1'b0;
        end else if (cancel) begin
          acc      <= 8'h00;
          acc_zero <= 1'b1;
        end
      end
      if (state == S_WAIT) begin
        if (bus.fpa_done) begin
          acc <= bus.fpa_sum;
        end else if (timeout) begin
          err <= 1'b1;
        end
      end
      if ((state == S_OUT) && bus.out_ready) begin
        acc      <= 8'h00;
        acc_zero <= 1'b1;
        last_q   <= 1'b0;
        err      <= 1'b0;
        cnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fpa_accum.sv
// tb/tb_fpa_accum.sv - directed self-checking bench for fpa_accum with a behavioural FPA stub
module tb_fpa_accum;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   go_cnt = 0;
  int   lat = 3;
  bit   hang = 1'b0;
  bit   busy = 1'b0;
  int   k = 0;
  int   g0;
  int   n;

  fpa_accum_if #(.COUNT_W(8)) bus ();

  fpa_accum #(.COUNT_W(8), .TIMEOUT(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fadd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] t;
    logic [3:0] d;
    logic [4:0] ma, mb, s;
    if (a[6:3] < b[6:3]) begin
      t = a; a = b; b = t;
    end
    d  = a[6:3] - b[6:3];
    ma = {2'b01, a[2:0]};
    mb = {2'b01, b[2:0]} >> d;
    s  = ma + mb;
    if (s[4]) return {a[7], a[6:3] + 4'd1, s[3:1]};
    return {a[7], a[6:3], s[2:0]};
  endfunction

  // Adder stub: samples on the negedge, done after lat cycles, sticky until fpa_clr.
  always @(negedge clk) begin
    if (bus.fpa_clr === 1'b1) begin
      bus.fpa_done <= 1'b0;
      busy         <= 1'b0;
      k            <= 0;
    end else if (bus.fpa_go === 1'b1) begin
      busy <= 1'b1;
      k    <= 0;
    end else if (busy && !hang) begin
      if (k + 1 == lat) begin
        bus.fpa_done <= 1'b1;
        bus.fpa_sum  <= fadd(bus.fpa_a, bus.fpa_b);
        busy         <= 1'b0;
      end
      k <= k + 1;
    end
  end

  always @(posedge clk) begin
    if (bus.fpa_go === 1'b1) go_cnt <= go_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int w;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("out_valid_wait", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_out_data"},  {24'd0, bus.out_data},  32'd0);
    check({tag, "_out_zero"},  {31'd0, bus.out_zero},  32'd0);
    check({tag, "_out_count"}, {24'd0, bus.out_count}, 32'd0);
    check({tag, "_out_err"},   {31'd0, bus.out_err},   32'd0);
    check({tag, "_fpa_clr"},   {31'd0, bus.fpa_clr},   32'd1);
    check({tag, "_fpa_go"},    {31'd0, bus.fpa_go},    32'd0);
    check({tag, "_fpa_a"},     {24'd0, bus.fpa_a},     32'd0);
    check({tag, "_fpa_b"},     {24'd0, bus.fpa_b},     32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    clr = 1'b0;
    tick();
    check("accept_after_clr", {31'd0, bus.in_ready}, 32'd1);

    // 1.0 + 1.0 = 2.0
    g0 = go_cnt;
    send(8'h40, 1'b0);
    check("direct_load_ready", {31'd0, bus.in_ready}, 32'd1);
    send(8'h40, 1'b1);
    wait_out(n);
    check("add_latency", n, 32'd5);
    check("p1_data",  {24'd0, bus.out_data},  32'h48);
    check("p1_count", {24'd0, bus.out_count}, 32'd2);
    check("p1_zero",  {31'd0, bus.out_zero},  32'd0);
    check("p1_err",   {31'd0, bus.out_err},   32'd0);
    check("p1_go",    go_cnt - g0,            32'd1);
    drain();
    check("p1_accept", {31'd0, bus.in_ready},  32'd1);
    check("p1_drop",   {31'd0, bus.out_valid}, 32'd0);

    // Exact cancellation never reaches the adder
    g0 = go_cnt;
    send(8'h40, 1'b0);
    send(8'hC0, 1'b1);
    check("p2_valid", {31'd0, bus.out_valid}, 32'd1);
    check("p2_zero",  {31'd0, bus.out_zero},  32'd1);
    check("p2_data",  {24'd0, bus.out_data},  32'h00);
    check("p2_count", {24'd0, bus.out_count}, 32'd2);
    check("p2_go",    go_cnt - g0,            32'd0);
    drain();

    // Single operand: valid the cycle right after the accepting edge
    g0 = go_cnt;
    send(8'h3A, 1'b1);
    check("p3_valid", {31'd0, bus.out_valid}, 32'd1);
    check("p3_data",  {24'd0, bus.out_data},  32'h3A);
    check("p3_count", {24'd0, bus.out_count}, 32'd1);
    check("p3_go",    go_cnt - g0,            32'd0);
    drain();

    // Three operands, two adds, then backpressure with the next packet waiting
    g0 = go_cnt;
    send(8'h40, 1'b0);
    send(8'h40, 1'b0);
    send(8'h48, 1'b1);
    wait_out(n);
    check("p4_data",  {24'd0, bus.out_data},  32'h50);
    check("p4_count", {24'd0, bus.out_count}, 32'd3);
    check("p4_go",    go_cnt - g0,            32'd2);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3A;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_data",  {24'd0, bus.out_data},  32'h50);
      check("bp_ready", {31'd0, bus.in_ready},  32'd0);
    end
    drain();
    check("bp_accept", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("p5_valid", {31'd0, bus.out_valid}, 32'd1);
    check("p5_data",  {24'd0, bus.out_data},  32'h3A);
    check("p5_count", {24'd0, bus.out_count}, 32'd1);
    drain();

    // Reset in the middle of a hung add discards the packet
    hang = 1'b1;
    send(8'h40, 1'b0);
    send(8'h48, 1'b1);
    repeat (4) tick();
    check("midwait_fpa_clr", {31'd0, bus.fpa_clr}, 32'd0);
    clr = 1'b1;
    #1;
    check_reset_outputs("midclr");
    tick();
    clr = 1'b0;
    hang = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid === 1'b1) n++;
    end
    check("midclr_no_out", n, 32'd0);
    check("midclr_accept", {31'd0, bus.in_ready}, 32'd1);

`ifdef FPA_ACCUM_TIMEOUT_EN
    hang = 1'b1;
    send(8'h40, 1'b0);
    send(8'h48, 1'b1);
    wait_out(n);
    check("to_latency", n, 32'd10);
    check("to_err",     {31'd0, bus.out_err},   32'd1);
    check("to_data",    {24'd0, bus.out_data},  32'h40);
    check("to_count",   {24'd0, bus.out_count}, 32'd2);
    check("to_fpa_clr", {31'd0, bus.fpa_clr},   32'd1);
    drain();
    hang = 1'b0;
    send(8'h3A, 1'b1);
    check("to_err_clear", {31'd0, bus.out_err}, 32'd0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
